// File: rtl/desc_win_scan.sv
// desc_win_scan: walks the 16x16 SIFT descriptor sampling grid around a keypoint.
// Each grid point drives one rotated-offset ROM address. The signed x/y offsets are
// added to the keypoint, and absolute sample coordinates stream out over valid/ready.
// Optional macro DESC_SCAN_CLAMP_EN: when defined, coordinates saturate to the image
// and smp_oob flags out-of-image samples. When undefined, coordinates wrap and smp_oob is 0.
module desc_win_scan #(
  parameter int COORD_W = 11,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] kp_x,
  input  logic [COORD_W-1:0] kp_y,
  output logic               busy,
  output logic [7:0]         rom_a,
  input  logic [4:0]         rom_dx,
  input  logic [4:0]         rom_dy,
  output logic [COORD_W-1:0] smp_x,
  output logic [COORD_W-1:0] smp_y,
  output logic [7:0]         smp_idx,
  output logic               smp_oob,
  output logic               smp_valid,
  input  logic               smp_ready,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [7:0]         r_idx;
  logic [COORD_W-1:0] r_kp_x;
  logic [COORD_W-1:0] r_kp_y;
  logic [COORD_W-1:0] r_smp_x;
  logic [COORD_W-1:0] r_smp_y;
  logic [7:0]         r_smp_idx;
  logic               r_smp_oob;
  logic               r_valid;
  logic               r_done;
  logic               r_busy;

  logic               w_load;
  logic [COORD_W-1:0] w_smp_x;
  logic [COORD_W-1:0] w_smp_y;
  logic               w_smp_oob;

  // The output register accepts a new sample whenever it is empty or being drained this cycle.
  assign w_load = (r_state == S_SCAN) && (!r_valid || smp_ready);

`ifdef DESC_SCAN_CLAMP_EN
  // Two extra bits give a sign bit plus headroom, so kp near 2^COORD_W-1 plus +15 cannot overflow.
  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] XMAX = SW'(IMG_W - 1);
  localparam logic signed [SW-1:0] YMAX = SW'(IMG_H - 1);

  logic signed [SW-1:0] w_sx;
  logic signed [SW-1:0] w_sy;
  logic                 w_x_lo;
  logic                 w_x_hi;
  logic                 w_y_lo;
  logic                 w_y_hi;

  assign w_sx   = $signed({2'b00, r_kp_x}) + $signed({{(SW-5){rom_dx[4]}}, rom_dx});
  assign w_sy   = $signed({2'b00, r_kp_y}) + $signed({{(SW-5){rom_dy[4]}}, rom_dy});
  assign w_x_lo = w_sx[SW-1];
  assign w_y_lo = w_sy[SW-1];
  assign w_x_hi = (w_sx > XMAX);
  assign w_y_hi = (w_sy > YMAX);

  // Saturate each coordinate to the image. The oob flag reports the pre-clamp position.
  always_comb begin
    w_smp_x   = w_sx[COORD_W-1:0];
    w_smp_y   = w_sy[COORD_W-1:0];
    w_smp_oob = w_x_lo || w_x_hi || w_y_lo || w_y_hi;
    if (w_x_lo) begin
      w_smp_x = '0;
    end else if (w_x_hi) begin
      w_smp_x = XMAX[COORD_W-1:0];
    end
    if (w_y_lo) begin
      w_smp_y = '0;
    end else if (w_y_hi) begin
      w_smp_y = YMAX[COORD_W-1:0];
    end
  end
`else
  // Wrapping build: a modular add at COORD_W bits yields the low bits of the signed sum.
  assign w_smp_x   = r_kp_x + {{(COORD_W-5){rom_dx[4]}}, rom_dx};
  assign w_smp_y   = r_kp_y + {{(COORD_W-5){rom_dy[4]}}, rom_dy};
  assign w_smp_oob = 1'b0;
`endif

  // Scan FSM: latches the keypoint, steps the grid index on each load, and drains the last sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_kp_x    <= '0;
      r_kp_y    <= '0;
      r_smp_x   <= '0;
      r_smp_y   <= '0;
      r_smp_idx <= '0;
      r_smp_oob <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !r_done) begin
            r_kp_x  <= kp_x;
            r_kp_y  <= kp_y;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_load) begin
            r_smp_x   <= w_smp_x;
            r_smp_y   <= w_smp_y;
            r_smp_oob <= w_smp_oob;
            r_smp_idx <= r_idx;
            r_valid   <= 1'b1;
            if (r_idx == 8'hFF) begin
              r_state <= S_DRAIN;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (smp_ready) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign rom_a     = r_idx;
  assign smp_x     = r_smp_x;
  assign smp_y     = r_smp_y;
  assign smp_idx   = r_smp_idx;
  assign smp_oob   = r_smp_oob;
  assign smp_valid = r_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_desc_win_scan.sv
// Testbench for desc_win_scan. A stub ROM built from random offset tables feeds the DUT.
// Every accepted sample is compared with a plain-arithmetic model of the sampling rules.
// Set DESC_SCAN_CLAMP_EN to match the DUT build.
module tb_desc_win_scan;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] kpX;
  logic [10:0] kpY;
  logic        busy;
  logic [7:0]  romA;
  logic [4:0]  romDx;
  logic [4:0]  romDy;
  logic [10:0] smpX;
  logic [10:0] smpY;
  logic [7:0]  smpIdx;
  logic        smpOob;
  logic        smpValid;
  logic        smpReady;
  logic        done;

  logic [4:0] dxTbl [256];
  logic [4:0] dyTbl [256];

  int checks;
  int errors;

  int gotX [$];
  int gotY [$];
  int gotIdx [$];
  int gotOob [$];
  int donePulses;
  int doneBusy;
  int doneCycle;
  int stableErrs;
  bit timedOut;
  logic busyAfterStart;
  logic validAfterStart;
  logic validAfterTwo;
  logic busyAfterDoneStart;

  desc_win_scan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kp_x      (kpX),
    .kp_y      (kpY),
    .busy      (busy),
    .rom_a     (romA),
    .rom_dx    (romDx),
    .rom_dy    (romDy),
    .smp_x     (smpX),
    .smp_y     (smpY),
    .smp_idx   (smpIdx),
    .smp_oob   (smpOob),
    .smp_valid (smpValid),
    .smp_ready (smpReady),
    .done      (done)
  );

  // The stub ROM answers combinationally from whatever address the scanner presents.
  assign romDx = dxTbl[romA];
  assign romDy = dyTbl[romA];

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converts a 5-bit two's-complement ROM offset to a signed integer.
  function automatic int offsetValue(input logic [4:0] d);
    int v;
    v = int'(d);
    if (v > 15) v = v - 32;
    return v;
  endfunction

  // Model: the coordinate a sample should report, given the keypoint, offset and image limit.
  function automatic int expCoord(input int kp, input logic [4:0] d, input int lim);
    int s;
    s = kp + offsetValue(d);
`ifdef DESC_SCAN_CLAMP_EN
    if (s < 0) return 0;
    if (s > lim) return lim;
    return s;
`else
    return s & 2047;
`endif
  endfunction

  // Model: whether a sample lies outside the image. Only the clamp build reports this.
  function automatic int expOob(input int kx, input int ky, input int i);
`ifdef DESC_SCAN_CLAMP_EN
    int sx;
    int sy;
    sx = kx + offsetValue(dxTbl[i]);
    sy = ky + offsetValue(dyTbl[i]);
    return ((sx < 0) || (sx > 639) || (sy < 0) || (sy > 479)) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Returns the position of the first collected sample that disagrees with the model, or -1.
  function automatic int firstBadSample(input int kx, input int ky);
    for (int k = 0; k < gotIdx.size(); k++) begin
      if (gotIdx[k] != k) return k;
      if (gotX[k] != expCoord(kx, dxTbl[k], 639)) return k;
      if (gotY[k] != expCoord(ky, dyTbl[k], 479)) return k;
      if (gotOob[k] != expOob(kx, ky, k)) return k;
    end
    return -1;
  endfunction

  // Fills the stub ROM with fresh random offsets.
  task automatic fillTables();
    for (int i = 0; i < 256; i++) begin
      dxTbl[i] = 5'($urandom);
      dyTbl[i] = 5'($urandom);
    end
  endtask

  // Starts one scan and runs it to completion while collecting accepted samples.
  // readyMode selects the ready stimulus: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
  // injStartAt >= 0 pulses a stray start once that many samples have been accepted.
  // injStartOnDone pulses start in the same cycle that done is high.
  task automatic applyStimulus(input int kx, input int ky, input int readyMode,
                               input int injStartAt, input bit injStartOnDone);
    bit heldValid;
    bit injected;
    bit doneSeen;
    bit rdy;
    int cyc;
    int extra;
    logic [10:0] hx;
    logic [10:0] hy;
    logic [7:0]  hi;
    logic        ho;
    gotX.delete();
    gotY.delete();
    gotIdx.delete();
    gotOob.delete();
    donePulses = 0;
    doneBusy = 0;
    doneCycle = -1;
    stableErrs = 0;
    timedOut = 0;
    busyAfterDoneStart = 1'bx;
    heldValid = 0;
    injected = 0;
    doneSeen = 0;
    extra = 0;
    cyc = 0;
    hx = '0;
    hy = '0;
    hi = '0;
    ho = 1'b0;
    @(negedge clk);
    kpX = 11'(kx);
    kpY = 11'(ky);
    start = 1'b1;
    smpReady = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      kpX = 11'(kx);
      kpY = 11'(ky);
      if (cyc == 1) begin
        busyAfterStart = busy;
        validAfterStart = smpValid;
      end
      if (cyc == 2) validAfterTwo = smpValid;
      if (heldValid && (smpValid !== 1'b1 || smpX !== hx || smpY !== hy ||
                        smpIdx !== hi || smpOob !== ho)) begin
        stableErrs++;
      end
      if (done === 1'b1) begin
        donePulses++;
        if (busy !== 1'b0) doneBusy++;
      end
      if (doneSeen) begin
        extra++;
        if (extra == 1 && injStartOnDone) busyAfterDoneStart = busy;
        if (extra >= 3) break;
      end else if (done === 1'b1) begin
        doneSeen = 1;
        doneCycle = cyc;
        if (injStartOnDone) begin
          start = 1'b1;
          kpX = 11'd7;
          kpY = 11'd9;
        end
      end
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 1) || ((cyc % 4) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      smpReady = rdy;
      if (smpValid === 1'b1 && rdy) begin
        gotX.push_back(int'(smpX));
        gotY.push_back(int'(smpY));
        gotIdx.push_back(int'(smpIdx));
        gotOob.push_back(int'(smpOob));
      end
      heldValid = (smpValid === 1'b1) && !rdy;
      hx = smpX;
      hy = smpY;
      hi = smpIdx;
      ho = smpOob;
      if (!injected && injStartAt >= 0 && gotIdx.size() == injStartAt) begin
        start = 1'b1;
        kpX = 11'd300;
        kpY = 11'd300;
        injected = 1;
      end
      if (cyc >= 3000) begin
        timedOut = 1;
        break;
      end
    end
    start = 1'b0;
    smpReady = 1'b0;
  endtask

  // Reset state, plus ready asserted while nothing is valid.
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    smpReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, smpValid, done, smpOob} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: busy/valid/done/oob got %b expected 0000", {busy, smpValid, done, smpOob});
    end
    checks++;
    if ({romA, smpIdx} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_addr: rom_a %0d smp_idx %0d expected 0 0", romA, smpIdx);
    end
    checks++;
    if ({smpX, smpY} !== 22'h0) begin
      errors++;
      $display("[TB] FAIL reset_coord: smp_x %0d smp_y %0d expected 0 0", smpX, smpY);
    end
    rst_n = 1'b1;
    smpReady = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, smpValid, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_ready: busy/valid/done got %b expected 000", {busy, smpValid, done});
    end
    smpReady = 1'b0;
  endtask

  // Nominal scan with ready always high: latency, first sample, throughput and done pulse.
  task automatic test_nominal();
    int bad;
    fillTables();
    dxTbl[0] = 5'h05;
    dyTbl[0] = 5'h17;
    applyStimulus(100, 50, 0, -1, 1'b0);
    checks++;
    if (timedOut) begin
      errors++;
      $display("[TB] FAIL nominal_timeout: scan did not finish, got %0d samples expected 256", gotIdx.size());
    end
    checks++;
    if ({busyAfterStart, validAfterStart, validAfterTwo} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL nominal_latency: busy/valid after E, valid after E+1 got %b expected 101",
               {busyAfterStart, validAfterStart, validAfterTwo});
    end
    checks++;
    if (gotIdx.size() !== 256) begin
      errors++;
      $display("[TB] FAIL nominal_count: got %0d samples expected 256", gotIdx.size());
    end
    if (gotIdx.size() > 0) begin
      checks++;
      if (gotX[0] !== 105 || gotY[0] !== 41 || gotIdx[0] !== 0) begin
        errors++;
        $display("[TB] FAIL nominal_first: got x=%0d y=%0d idx=%0d expected x=105 y=41 idx=0",
                 gotX[0], gotY[0], gotIdx[0]);
      end
    end
    bad = firstBadSample(100, 50);
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL nominal_samples: sample %0d got idx=%0d x=%0d y=%0d oob=%0d expected idx=%0d x=%0d y=%0d oob=%0d",
               bad, gotIdx[bad], gotX[bad], gotY[bad], gotOob[bad], bad,
               expCoord(100, dxTbl[bad], 639), expCoord(50, dyTbl[bad], 479), expOob(100, 50, bad));
    end
    checks++;
    if (donePulses !== 1 || doneBusy !== 0) begin
      errors++;
      $display("[TB] FAIL nominal_done: done pulses %0d busy-at-done %0d expected 1 0", donePulses, doneBusy);
    end
    checks++;
    if (doneCycle !== 258) begin
      errors++;
      $display("[TB] FAIL nominal_rate: done in cycle %0d after start expected 258", doneCycle);
    end
  endtask

  // Ready toggling 1,0,0,1: held samples must stay stable and indices must stay in order.
  task automatic test_backpressure();
    int kx;
    int ky;
    int bad;
    fillTables();
    kx = $urandom_range(0, 700);
    ky = $urandom_range(0, 700);
    applyStimulus(kx, ky, 1, -1, 1'b0);
    checks++;
    if (stableErrs !== 0) begin
      errors++;
      $display("[TB] FAIL bp_stable: got %0d unstable held cycles expected 0", stableErrs);
    end
    checks++;
    if (gotIdx.size() !== 256 || donePulses !== 1) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d samples %0d done pulses expected 256 1", gotIdx.size(), donePulses);
    end
    bad = firstBadSample(kx, ky);
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL bp_samples: sample %0d got idx=%0d x=%0d y=%0d expected idx=%0d x=%0d y=%0d",
               bad, gotIdx[bad], gotX[bad], gotY[bad], bad,
               expCoord(kx, dxTbl[bad], 639), expCoord(ky, dyTbl[bad], 479));
    end
  endtask

  // Keypoint at the image corner with offsets pushing the sample outside the image.
  task automatic test_border();
    int wantX;
    int wantY;
    int wantOob;
    fillTables();
    dxTbl[0] = 5'h10;
    dyTbl[0] = 5'h0F;
`ifdef DESC_SCAN_CLAMP_EN
    wantX = 0;
    wantY = 479;
    wantOob = 1;
`else
    wantX = 2034;
    wantY = 493;
    wantOob = 0;
`endif
    applyStimulus(2, 478, 2, -1, 1'b0);
    checks++;
    if (gotIdx.size() !== 256) begin
      errors++;
      $display("[TB] FAIL border_count: got %0d samples expected 256", gotIdx.size());
    end
    if (gotIdx.size() > 0) begin
      checks++;
      if (gotX[0] !== wantX || gotY[0] !== wantY || gotOob[0] !== wantOob) begin
        errors++;
        $display("[TB] FAIL border_first: got x=%0d y=%0d oob=%0d expected x=%0d y=%0d oob=%0d",
                 gotX[0], gotY[0], gotOob[0], wantX, wantY, wantOob);
      end
    end
    checks++;
    if (firstBadSample(2, 478) !== -1) begin
      errors++;
      $display("[TB] FAIL border_samples: first bad sample %0d expected -1", firstBadSample(2, 478));
    end
  endtask

  // A start pulse at sample 40 must not disturb the keypoint or the sample count.
  task automatic test_start_busy();
    int kx;
    int ky;
    int bad;
    fillTables();
    kx = $urandom_range(0, 600);
    ky = $urandom_range(0, 400);
    applyStimulus(kx, ky, 0, 40, 1'b0);
    checks++;
    if (gotIdx.size() !== 256 || donePulses !== 1) begin
      errors++;
      $display("[TB] FAIL busy_start_count: got %0d samples %0d done pulses expected 256 1", gotIdx.size(), donePulses);
    end
    bad = firstBadSample(kx, ky);
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL busy_start_kp: sample %0d got x=%0d y=%0d expected x=%0d y=%0d",
               bad, gotX[bad], gotY[bad], expCoord(kx, dxTbl[bad], 639), expCoord(ky, dyTbl[bad], 479));
    end
  endtask

  // Start coinciding with done is dropped. A later start then scans normally.
  task automatic test_back_to_back();
    int kx;
    int ky;
    fillTables();
    applyStimulus($urandom_range(0, 700), $urandom_range(0, 700), 0, -1, 1'b1);
    checks++;
    if (busyAfterDoneStart !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_ignored: busy after start-with-done got %b expected 0", busyAfterDoneStart);
    end
    kx = $urandom_range(0, 700);
    ky = $urandom_range(0, 700);
    applyStimulus(kx, ky, 2, -1, 1'b0);
    checks++;
    if (gotIdx.size() !== 256 || firstBadSample(kx, ky) !== -1) begin
      errors++;
      $display("[TB] FAIL b2b_rescan: got %0d samples first bad %0d expected 256 -1",
               gotIdx.size(), firstBadSample(kx, ky));
    end
  endtask

  // Reset at sample 100 aborts the scan cleanly. A new start restarts from index 0.
  task automatic test_mid_reset();
    bit found;
    int dcount;
    int kx;
    int ky;
    fillTables();
    @(negedge clk);
    kpX = 11'd320;
    kpY = 11'd240;
    start = 1'b1;
    smpReady = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 400; c++) begin
      if (smpValid === 1'b1 && smpIdx === 8'd100) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL mid_reset_reach: sample 100 seen %0d expected 1", found);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, smpValid, done} !== 3'b000 || romA !== 8'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_state: busy/valid/done %b rom_a %0d expected 000 0", {busy, smpValid, done}, romA);
    end
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done === 1'b1 || smpValid === 1'b1) dcount++;
    end
    checks++;
    if (dcount !== 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_quiet: got %0d cycles with done or valid expected 0", dcount);
    end
    kx = $urandom_range(0, 700);
    ky = $urandom_range(0, 700);
    applyStimulus(kx, ky, 0, -1, 1'b0);
    checks++;
    if (gotIdx.size() !== 256 || firstBadSample(kx, ky) !== -1) begin
      errors++;
      $display("[TB] FAIL mid_reset_rescan: got %0d samples first bad %0d expected 256 -1",
               gotIdx.size(), firstBadSample(kx, ky));
    end
  endtask

  // Several scans with random keypoints, offsets and ready patterns.
  task automatic test_random();
    int kx;
    int ky;
    for (int n = 0; n < 3; n++) begin
      fillTables();
      kx = $urandom_range(0, 700);
      ky = $urandom_range(0, 700);
      applyStimulus(kx, ky, 2, -1, 1'b0);
      checks++;
      if (gotIdx.size() !== 256 || stableErrs !== 0 || donePulses !== 1 || firstBadSample(kx, ky) !== -1) begin
        errors++;
        $display("[TB] FAIL random_scan%0d: samples %0d unstable %0d done %0d first bad %0d expected 256 0 1 -1",
                 n, gotIdx.size(), stableErrs, donePulses, firstBadSample(kx, ky));
      end
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    kpX = '0;
    kpY = '0;
    smpReady = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dxTbl[i] = 5'h00;
      dyTbl[i] = 5'h00;
    end
    test_reset();
    test_nominal();
    test_backpressure();
    test_border();
    test_start_busy();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
